// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: sequences one neuron evaluation. It fetches `len` weight/input
// pairs from a 1-cycle-latency memory, multiply-accumulates them, applies ReLU
// with saturation and hands the result off on a valid/ready interface.
module neuron_seq_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned ACC_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_w,
    input  logic [WIDTH-1:0]  rd_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat
);

    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
    localparam logic [WIDTH-1:0] DataMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                strobe_q;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [ACC_W-1:0]    out_acc_q, out_acc_d;
    logic                out_sat_q, out_sat_d;

    logic [LEN_W-1:0]    len_clamped;
    logic                last_addr;
    logic [2*WIDTH-1:0]  w_ext;
    logic [2*WIDTH-1:0]  x_ext;
    logic [2*WIDTH-1:0]  prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIDTH-1:0]    relu_data;
    logic                relu_sat;

    // Operand conditioning, full-width signed product and accumulator sum.
    always_comb begin
        len_clamped = (len > LenMax) ? LenMax : len;
        last_addr   = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));
        // Sign-extending both operands first makes the low 2*WIDTH bits of the
        // unsigned product equal to the signed product.
        w_ext    = {{WIDTH{rd_w[WIDTH-1]}}, rd_w};
        x_ext    = {{WIDTH{rd_x[WIDTH-1]}}, rd_x};
        prod     = w_ext * x_ext;
        prod_ext = {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
        acc_sum  = acc_q + prod_ext;
    end

    // FSM next state, length latch, address counter and accumulator update.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = strobe_q ? acc_sum : acc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                // Hold the counter on the last address so it never wraps.
                if (last_addr) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ReLU with saturation applied to the accumulator value about to be stored.
    always_comb begin
        relu_data = '0;
        relu_sat  = 1'b0;
        if (!acc_d[ACC_W-1]) begin
            if (|acc_d[ACC_W-2:WIDTH]) begin
                relu_data = DataMax;
                relu_sat  = 1'b1;
            end else begin
                relu_data = acc_d[WIDTH-1:0];
            end
        end
    end

    // Result registers: load on entry to DONE, clear on return to IDLE.
    always_comb begin
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        out_sat_d  = out_sat_q;
        if (state_d == StDone && state_q != StDone) begin
            out_data_d = relu_data;
            out_acc_d  = acc_d;
            out_sat_d  = relu_sat;
        end else if (state_q == StDone && state_d == StIdle) begin
            out_data_d = '0;
            out_acc_d  = '0;
            out_sat_d  = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            strobe_q   <= 1'b0;
            out_data_q <= '0;
            out_acc_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            // Memory data lags the strobe by one cycle.
            strobe_q   <= rd_en;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy      = (state_q != StIdle);
        rd_en     = (state_q == StFetch);
        rd_addr   = rd_en ? cnt_q : '0;
        out_valid = (state_q == StDone);
        out_data  = out_data_q;
        out_acc   = out_acc_q;
        out_sat   = out_sat_q;
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Testbench for neuron_seq_ctrl: a memory model answers reads one cycle late,
// expected results go into a scoreboard queue when a run is launched and are
// popped and compared when the result appears.
module tb_neuron_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int ADDR_W  = 4;
    localparam int LEN_W   = 5;
    localparam int ACC_W   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_w;
    logic [WIDTH-1:0]  rd_x;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ACC_W-1:0]  out_acc;
    logic              out_sat;

    always #5 clk = ~clk;

    neuron_seq_ctrl #(
        .WIDTH  (WIDTH),
        .MAX_LEN(MAX_LEN),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_w     (rd_w),
        .rd_x     (rd_x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_acc  (out_acc),
        .out_sat  (out_sat)
    );

    logic signed [WIDTH-1:0] mem_w [MAX_LEN];
    logic signed [WIDTH-1:0] mem_x [MAX_LEN];

    // Synchronous memory: data for an address appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_w <= mem_w[rd_addr];
            rd_x <= mem_x[rd_addr];
        end
    end

    typedef struct {
        int acc;
        int data;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model of one evaluation over the first l memory entries.
    task automatic push_expected(input int l);
        exp_t e;
        int   acc = 0;
        for (int k = 0; k < l; k++) acc += int'(mem_w[k]) * int'(mem_x[k]);
        e.acc  = acc;
        e.sat  = (acc > 255) ? 1 : 0;
        e.data = (acc <= 0) ? 0 : ((acc > 255) ? 255 : acc);
        sb.push_back(e);
    endtask

    task automatic load_all(input int w, input int x);
        for (int k = 0; k < MAX_LEN; k++) begin
            mem_w[k] = 8'(w);
            mem_x[k] = 8'(x);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic start_run(input int drive_len);
        start = 1'b1;
        len   = LEN_W'(drive_len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows the fetch sequence and compares the result when it appears.
    task automatic wait_result(input int l);
        int   cyc  = 1;
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            check_eq("rd_en", int'(rd_en), (cyc <= l) ? 1 : 0);
            if (cyc <= l) check_eq("rd_addr", int'(rd_addr), cyc - 1);
            @(negedge clk);
            cyc++;
        end
        if (!seen) begin
            check_eq("valid_timeout", 0, 1);
        end else begin
            check_eq("latency", cyc, (l == 0) ? 1 : l + 2);
            check_eq("rd_en_done", int'(rd_en), 0);
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check_eq("out_acc", int'($signed(out_acc)), e.acc);
                check_eq("out_data", int'(out_data), e.data);
                check_eq("out_sat", int'(out_sat), e.sat);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_data"}, int'(out_data), 0);
        check_eq({tag, "_acc"}, int'(out_acc), 0);
        check_eq({tag, "_sat"}, int'(out_sat), 0);
        check_eq({tag, "_rd_en"}, int'(rd_en), 0);
        check_eq({tag, "_rd_addr"}, int'(rd_addr), 0);
    endtask

    // Handshake completes with out_ready high; next cycle must be IDLE.
    task automatic finish_handshake(input string tag);
        @(negedge clk);
        check_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        load_all(0, 0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        // Mixed signs, negative result.
        mem_w[0] = 8'sd2;  mem_w[1] = -8'sd3; mem_w[2] = 8'sd4;
        mem_x[0] = 8'sd5;  mem_x[1] = 8'sd6;  mem_x[2] = -8'sd1;
        push_expected(3);
        start_run(3);
        wait_result(3);
        finish_handshake("t1_idle");

        // Single term, in range.
        mem_w[0] = 8'sd7; mem_x[0] = 8'sd9;
        push_expected(1);
        start_run(1);
        wait_result(1);
        finish_handshake("t2_idle");

        // Saturation.
        mem_w[0] = 8'sd100; mem_w[1] = 8'sd100;
        mem_x[0] = 8'sd2;   mem_x[1] = 8'sd1;
        push_expected(2);
        start_run(2);
        wait_result(2);
        finish_handshake("t3_idle");

        // Full length, largest products.
        load_all(-128, -128);
        push_expected(16);
        start_run(16);
        wait_result(16);
        finish_handshake("t4_idle");

        // Oversized len clamps to MAX_LEN.
        for (int k = 0; k < MAX_LEN; k++) begin
            mem_w[k] = 8'(k + 1);
            mem_x[k] = 8'sd1;
        end
        push_expected(16);
        start_run(31);
        wait_result(16);
        finish_handshake("t5_idle");

        // Zero length.
        push_expected(0);
        start_run(0);
        wait_result(0);
        finish_handshake("t6_idle");

        // Backpressure, ignored start in DONE and in the handshake cycle.
        out_ready = 1'b0;
        mem_w[0] = 8'sd7; mem_x[0] = 8'sd9;
        push_expected(1);
        start_run(1);
        wait_result(1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = LEN_W'(2);
            @(negedge clk);
            check_eq("hold_valid", int'(out_valid), 1);
            check_eq("hold_data", int'(out_data), 63);
            check_eq("hold_acc", int'($signed(out_acc)), 63);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_busy", int'(busy), 0);
        check_eq("bp_valid", int'(out_valid), 0);
        mem_w[0] = 8'sd100; mem_w[1] = 8'sd100;
        mem_x[0] = 8'sd2;   mem_x[1] = 8'sd1;
        push_expected(2);
        start_run(2);
        wait_result(2);
        finish_handshake("t7_idle");

        // Reset abort during FETCH cycle 2, then a clean run.
        for (int k = 0; k < 4; k++) begin
            mem_w[k] = 8'sd50;
            mem_x[k] = 8'sd50;
        end
        start_run(4);
        @(negedge clk);
        check_eq("abort_rd_addr", int'(rd_addr), 1);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b1;
        mem_w[0] = 8'sd3; mem_x[0] = 8'sd3;
        push_expected(1);
        start_run(1);
        wait_result(1);
        finish_handshake("t8_idle");

        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_seq_ctrl.md
# neuron_seq_ctrl

Sequencer for one neuron evaluation: on `start` it reads `len` weight/input pairs from an external synchronous memory, multiply-accumulates them into a cleared signed accumulator, applies ReLU with saturation to WIDTH bits, and presents the result on a valid/ready output. It replaces free-running `en` control of the MAC-plus-ReLU datapath. It owns the read-address sequencing, the accumulator clear and the result hand-off to the next layer.

## Interface
- WIDTH, 8, signed width of weight and input operands
- MAX_LEN, 16, maximum terms per evaluation
- ADDR_W, 4, memory address width, equal to clog2(MAX_LEN)
- LEN_W, 5, width of `len`, equal to clog2(MAX_LEN+1)
- ACC_W, 20, accumulator width, at least 2*WIDTH+ADDR_W
- clk  in  1  single clock, rising edge
- rst  in  1  reset: synchronous, active-low
- start  in  1  request an evaluation; sampled only in IDLE
- len  in  LEN_W  term count, sampled with `start`; 0..MAX_LEN
- busy  out  1  high in every state except IDLE
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_w  in  WIDTH  signed weight, valid the cycle after `rd_en`
- rd_x  in  WIDTH  signed input, valid the cycle after `rd_en`
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  unsigned ReLU/saturated result
- out_acc  out  ACC_W  signed raw accumulator, for debug and verification
- out_sat  out  1  set when `out_data` was clipped at 2^WIDTH-1

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: all outputs are 0. On `start`=1:
  - `len` is latched and the accumulator and address counter clear.
  - If `len`≠0, go to FETCH. If `len`=0, go to DONE.
- FETCH:
  - `rd_en`=1 and `rd_addr`=counter; counter increments by 1 each cycle.
  - After the cycle issuing address `len`-1, go to DRAIN.
  - Counter never wraps: MAX_LEN-1 is the last address issued.
- Accumulate: a 1-cycle-delayed copy of `rd_en` qualifies the data. When it is set, acc <= acc + sign_ext(rd_w*rd_x).
  - The product is a full 2*WIDTH signed value.
  - The accumulator wraps modulo 2^ACC_W. The ACC_W rule above makes this unreachable.
- DRAIN: `rd_en`=0. The last product is accumulated. Go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_data` = 0 if acc≤0; acc if 0<acc≤2^WIDTH-1; otherwise 2^WIDTH-1 with `out_sat`=1.
  - `out_acc` = acc.
  - All outputs hold stable until `out_valid`&&`out_ready`, then go to IDLE.
- Output registers:
  - `out_data`, `out_acc` and `out_sat` are registered on entry to DONE.
  - On return to IDLE they reset to 0.
- `start` outside IDLE is ignored. This includes the handshake cycle; a new `start` is honoured from the first IDLE cycle.
- `len`>MAX_LEN is clamped to MAX_LEN.
- Reset, taking priority over everything:
  - `rst`=0 at a rising edge forces IDLE and clears acc, the counter, the delayed strobe and every output to 0.
  - It aborts any evaluation in flight, including an unaccepted result.

## Timing
- Edge 0 is the edge that samples `start`; L = `len`.
- FETCH cycles 1..L: `rd_addr` = 0..L-1.
- Data for address k is consumed in cycle k+2.
- DRAIN is cycle L+1. `out_valid` rises after edge L+1, so it is first visible in cycle L+2.
- L=0: `out_valid` is first visible in cycle 1 with `out_data`=0, `out_acc`=0, and no `rd_en`.
- Handshake completes at the edge where `out_valid`&&`out_ready`.
  - `busy` and `out_valid` are 0 in the next cycle.
  - Minimum start-to-start period is L+3 cycles with `out_ready` tied high.
- The memory must return data exactly 1 cycle after `rd_en`. There is no stall input.

## Test plan
- L=3, w={2,-3,4}, x={5,6,-1}:
  - `rd_addr` 0,1,2 in cycles 1-3.
  - `out_valid` in cycle 5, `out_acc`=-12, `out_data`=0, `out_sat`=0.
- L=1, w=7, x=9 → `out_acc`=63, `out_data`=63, `out_valid` in cycle 3.
- L=2, w={100,100}, x={2,1}:
  - `out_acc`=300, `out_data`=255, `out_sat`=1.
  - L=16, all w=x=-128 → `out_acc`=262144, no wrap, `out_data`=255.
- L=0 → `out_valid` in cycle 1, `out_data`=0, `rd_en` never asserted.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE and pulse `start` → outputs stable, `start` ignored.
  - Then `out_ready`=1 → IDLE next cycle, `busy`=0.
  - `start` in the following cycle runs a fresh evaluation.
- Reset: drive `rst`=0 in FETCH cycle 2 of an L=4 run.
  - All outputs are 0 the next cycle.
  - A new L=1 run (w=3, x=3) gives `out_acc`=9, with no residue from the aborted run.
